// File: rtl/dll_pkg.sv
// Shared types for the doubly-linked multi-queue deque controller.
// Widths follow the default configuration; the top re-derives them from its own parameters.
package dll_pkg;

  localparam int ID_N  = 4;
  localparam int PTR_N = 16;
  localparam int ID_W  = $clog2(ID_N);
  localparam int PTR_W = $clog2(PTR_N);
  localparam int CNT_W = $clog2(PTR_N + 1);

  typedef enum logic [1:0] {
    PUSH_BACK  = 2'd0,
    PUSH_FRONT = 2'd1,
    POP_FRONT  = 2'd2,
    POP_BACK   = 2'd3
  } op_t;

  typedef struct packed {
    logic             valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;
  } queue_t;

  typedef struct packed {
    op_t              op;
    logic [ID_W-1:0]  id;
    logic             err;
    logic [PTR_W-1:0] ptr;
  } cmd_t;

  function automatic logic is_push(input op_t op);
    return ~op[1];
  endfunction

endpackage

// File: rtl/dll_ffs.sv
// Lowest-set-bit encoder: combinational, no backpressure.
// found is low and idx is zero when no bit of vec is set.
module dll_ffs #(
  parameter int N = 16,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/dll_deque_cntrl.sv
// Multi-queue deque over a shared pointer pool: S0 accept/lookup, S1 link update.
// Response one cycle after accept; one command in flight, cmd_ready low while busy or clearing.
module dll_deque_cntrl
  import dll_pkg::*;
#(
  parameter int  ID_N  = 4,
  parameter int  PTR_N = 16,
  localparam int ID_W  = $clog2(ID_N),
  localparam int PTR_W = $clog2(PTR_N),
  localparam int CNT_W = $clog2(PTR_N + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ID_W-1:0]       cmd_id,
  output logic                  rsp_valid,
  output logic [PTR_W-1:0]      rsp_ptr,
  output logic                  rsp_err,
  input  logic                  clear,
  output logic                  full_r,
  output logic                  empty_r,
  output logic [ID_N-1:0]       nempty_r,
  output logic [ID_N*CNT_W-1:0] cnt_r
);

  typedef struct packed {
    logic             valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;
  } qent_t;

  typedef struct packed {
    op_t              op;
    logic [ID_W-1:0]  id;
    logic             err;
    logic [PTR_W-1:0] ptr;
  } s1_t;

  logic             rdy_en;
  logic             busy_r;
  s1_t              s1_r, s1_nxt;
  qent_t            q_r   [ID_N];
  qent_t            q_nxt [ID_N];
  qent_t            qs, qc;
  logic [PTR_N-1:0] used_r, used_nxt;
  logic [PTR_W-1:0] nxt_tbl [PTR_N];
  logic [PTR_W-1:0] prv_tbl [PTR_N];
  logic             nxt_we, prv_we;
  logic [PTR_W-1:0] nxt_wa, nxt_wd, prv_wa, prv_wd;
  logic             free_found;
  logic [PTR_W-1:0] free_idx;
  logic             accept;
  op_t              op_in;

  assign cmd_ready = rdy_en & ~busy_r & ~clear;
  assign accept    = cmd_valid & cmd_ready;
  assign op_in     = op_t'(cmd_op);

  dll_ffs #(.N(PTR_N)) u_ffs (
    .vec   (~used_r),
    .found (free_found),
    .idx   (free_idx)
  );

  // S0: decide the outcome and the pointer now so the response can leave from S1.
  always_comb begin
    qs         = q_r[cmd_id];
    s1_nxt     = '0;
    s1_nxt.op  = op_in;
    s1_nxt.id  = cmd_id;
    if (is_push(op_in)) begin
      s1_nxt.err = ~free_found;
      s1_nxt.ptr = free_found ? free_idx : '0;
    end else begin
      s1_nxt.err = ~qs.valid;
      if (qs.valid)
        s1_nxt.ptr = (op_in == POP_FRONT) ? qs.head : qs.tail;
    end
  end

  // S1: link and queue update; tables are still unchanged since S0.
  always_comb begin
    q_nxt    = q_r;
    used_nxt = used_r;
    nxt_we   = 1'b0;
    nxt_wa   = '0;
    nxt_wd   = '0;
    prv_we   = 1'b0;
    prv_wa   = '0;
    prv_wd   = '0;
    qc       = q_r[s1_r.id];
    if (busy_r && !s1_r.err) begin
      case (s1_r.op)
        PUSH_BACK: begin
          prv_we = 1'b1;
          prv_wa = s1_r.ptr;
          prv_wd = qc.tail;
          if (qc.valid) begin
            nxt_we = 1'b1;
            nxt_wa = qc.tail;
            nxt_wd = s1_r.ptr;
          end else begin
            qc.head = s1_r.ptr;
          end
          qc.tail  = s1_r.ptr;
          qc.valid = 1'b1;
          qc.cnt   = qc.cnt + CNT_W'(1);
          used_nxt[s1_r.ptr] = 1'b1;
        end
        PUSH_FRONT: begin
          nxt_we = 1'b1;
          nxt_wa = s1_r.ptr;
          nxt_wd = qc.head;
          if (qc.valid) begin
            prv_we = 1'b1;
            prv_wa = qc.head;
            prv_wd = s1_r.ptr;
          end else begin
            qc.tail = s1_r.ptr;
          end
          qc.head  = s1_r.ptr;
          qc.valid = 1'b1;
          qc.cnt   = qc.cnt + CNT_W'(1);
          used_nxt[s1_r.ptr] = 1'b1;
        end
        POP_FRONT: begin
          qc.head = nxt_tbl[qc.head];
          qc.cnt  = qc.cnt - CNT_W'(1);
          used_nxt[s1_r.ptr] = 1'b0;
        end
        default: begin
          qc.tail = prv_tbl[qc.tail];
          qc.cnt  = qc.cnt - CNT_W'(1);
          used_nxt[s1_r.ptr] = 1'b0;
        end
      endcase
      if (qc.cnt == '0)
        qc = '0;
      q_nxt[s1_r.id] = qc;
    end
    if (clear) begin
      for (int i = 0; i < ID_N; i++)
        q_nxt[i] = '0;
      used_nxt = '0;
      nxt_we   = 1'b0;
      prv_we   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en  <= 1'b0;
      busy_r  <= 1'b0;
      s1_r    <= '0;
      used_r  <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      for (int i = 0; i < ID_N; i++)
        q_r[i] <= '0;
    end else begin
      rdy_en  <= 1'b1;
      busy_r  <= accept;
      if (accept)
        s1_r <= s1_nxt;
      used_r  <= used_nxt;
      full_r  <= &used_nxt;
      empty_r <= ~|used_nxt;
      for (int i = 0; i < ID_N; i++)
        q_r[i] <= q_nxt[i];
    end
  end

  // Link contents only matter while the owning pointer is allocated.
  always_ff @(posedge clk) begin
    if (nxt_we)
      nxt_tbl[nxt_wa] <= nxt_wd;
    if (prv_we)
      prv_tbl[prv_wa] <= prv_wd;
  end

  assign rsp_valid = busy_r;
  assign rsp_ptr   = s1_r.ptr;
  assign rsp_err   = s1_r.err;

  always_comb begin
    for (int i = 0; i < ID_N; i++) begin
      nempty_r[i]              = q_r[i].valid;
      cnt_r[i*CNT_W +: CNT_W]  = q_r[i].cnt;
    end
  end

endmodule

// File: doc/dll_deque_cntrl.md
DLL_DEQUE_CNTRL -- requirements
Module: dll_deque_cntrl

Interface
REQ-001 SHALL have parameter ID_N, default 4: number of independent queues (>=2).
REQ-002 SHALL have parameter PTR_N, default 16: shared pointer pool entries (power of 2, >=4).
REQ-003 SHALL have derived widths ID_W=$clog2(ID_N), PTR_W=$clog2(PTR_N) and CNT_W=$clog2(PTR_N+1).
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid, input, 1: command offered.
REQ-007 SHALL have port cmd_ready, output, 1: command accepted when high with cmd_valid.
REQ-008 SHALL have port cmd_op, input, 2: 0 PUSH_BACK, 1 PUSH_FRONT, 2 POP_FRONT, 3 POP_BACK.
REQ-009 SHALL have port cmd_id, input, ID_W: target queue.
REQ-010 SHALL have port rsp_valid, output, 1: one-cycle response pulse.
REQ-011 SHALL have port rsp_ptr, output, PTR_W: pointer allocated on a push, or released on a pop.
REQ-012 SHALL have port rsp_err, output, 1: the command was rejected and caused no state change.
REQ-013 SHALL have port clear, input, 1: synchronous flush of all queues.
REQ-014 SHALL have ports full_r and empty_r, output, 1 each: pool status.
REQ-015 SHALL have port nempty_r, output, ID_N: per-queue non-empty flags.
REQ-016 SHALL have port cnt_r, output, ID_N*CNT_W: packed per-queue occupancy, queue 0 in the LSBs.

Function
REQ-017 SHALL implement a two-stage pipeline, with S0 accept/lookup and S1 link update, and SHALL allow one command in flight.
REQ-018 SHALL drive cmd_ready = ~busy_r & ~clear, where busy_r is the S1-valid flag; peak throughput is one command per two cycles.
REQ-019 SHALL pulse rsp_valid in cycle T+1 for a command accepted in cycle T; all table, flag and count updates SHALL be visible from T+2.
REQ-020 SHALL allocate the lowest-index free pointer in the pool on a push.
REQ-021 SHALL keep per-pointer next[] and prev[] link tables (register arrays, PTR_W each) and per-queue {valid, head, tail, cnt}.
REQ-022 PUSH_BACK SHALL do: new.prev=tail; next[tail]=new when the queue is non-empty; tail=new; head=new when the queue is empty.
REQ-023 PUSH_FRONT SHALL mirror PUSH_BACK with head/tail and next/prev swapped.
REQ-024 POP_FRONT SHALL return head, set head=next[head] and free that pointer; POP_BACK SHALL return tail, set tail=prev[tail] and free it.
REQ-025 A pop that leaves cnt==0 SHALL clear valid, head and tail to 0.
REQ-026 A pop on an empty queue SHALL return rsp_err=1 and rsp_ptr=0, with no state change.
REQ-027 A push while full_r is set SHALL return rsp_err=1 and rsp_ptr=0, with no state change.
REQ-028 full_r SHALL be registered and equal (all pool pointers in use); empty_r SHALL be registered and equal (no pointers in use).
REQ-029 Counts SHALL never wrap: cnt saturates by construction and the sum of cnt_r SHALL equal the number of pointers in use.
REQ-030 clear SHALL take priority over an in-flight S1 update: the in-flight command still produces rsp_valid, but its update is discarded; all queues and the pool become empty at the next edge.
REQ-031 cmd_op, cmd_id and cmd_valid SHALL be ignored when cmd_ready is low.

Reset
REQ-032 Asserting rst SHALL asynchronously force cmd_ready=0, rsp_valid=0, rsp_ptr=0, rsp_err=0, full_r=0, empty_r=1, nempty_r=0, cnt_r=0 and busy_r=0, and SHALL empty the pool and all queue entries.
REQ-033 cmd_ready SHALL rise in the first cycle after rst deasserts.
REQ-034 Assertion of rst mid-operation SHALL drop any in-flight command without a response.
REQ-035 next[] and prev[] SHALL need no reset; their contents are don't-care while the owning pointer is free.

Structure
REQ-036 dll_pkg SHALL hold the op_t enum, the queue_t struct {valid, head, tail, cnt} and the S1 cmd_t struct, all parametrised via package localparams; the module SHALL override those localparams consistently.
REQ-037 The design SHALL instantiate one sub-module, dll_ffs: a parametrised lowest-set-bit encoder with {found, index} outputs, used for free-pointer allocation.

Verification
REQ-038 Reset, then PUSH_BACK to q0 three times -> rsp_ptr 0,1,2; cnt_r[q0]=3; nempty_r=4'b0001.
REQ-039 Then PUSH_FRONT to q0 -> rsp_ptr=3; POP_FRONT x2 -> 3,0; POP_BACK x2 -> 2,1; finally nempty_r=0 and empty_r=1.
REQ-040 Interleave pushes across q0..q3 until 16 pointers are in use -> full_r=1; a 17th push -> rsp_err=1 and all counts unchanged.
REQ-041 POP_BACK on an empty q2 -> rsp_err=1 and rsp_ptr=0; a subsequent push to q2 -> rsp_err=0.
REQ-042 Assert clear in the cycle after a push is accepted -> rsp_valid still pulses, then cnt_r=0 and empty_r=1; the next push returns rsp_ptr=0.
REQ-043 Randomized push/pop run checked against a reference deque model; assert rst mid-run -> outputs match REQ-032 in the same cycle.
